// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: UART transmitter that drains a first-word-fall-through FIFO.
// Pops one word whenever idle and the FIFO has data, then sends it as
// start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
// The baud-rate divider is internal; every bit lasts CLKS_PER_BIT clocks.
module uart_fifo_tx #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                 Clock,
   input  logic                 ResetN,
   input  logic                 FifoEmpty,
   input  logic [DATA_BITS-1:0] FifoReadData,
   output logic                 FifoRead,
   output logic                 Tx,
   output logic                 TxBusy,
   output logic                 TxDoneTick
);

   // The counter is sized for the longest interval it times, the stop phase.
   localparam int CNT_W = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   // Reject parameter sets the frame logic cannot honour.
   generate
      if (CLKS_PER_BIT < 2 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
          DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_params
         $error("uart_fifo_tx: illegal parameters (CLKS_PER_BIT>=2, STOP_BITS 1/2, DATA_BITS 5..9)");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 pop;

   // Next-state, datapath and next-output decode; outputs are computed from
   // the next state so that the registered Tx changes on the state edge itself.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!FifoEmpty) begin
               pop     = 1'b1;
               shift_d = FifoReadData;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == BIT_END) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STOP: begin
            if (cnt_q == STOP_END) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tx_d = 1'b1;
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_STOP) && (cnt_d == STOP_END);
   end

   // A pop is only issued from IDLE, and never while reset is being applied.
   assign FifoRead = pop && ResetN;

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!ResetN) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Tx         = tx_q;
   assign TxBusy     = busy_q;
   assign TxDoneTick = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: two transmitters (1 and 2 stop bits) fed from FIFO models.
// Words pushed into a FIFO model are also pushed into a per-lane scoreboard;
// a monitor pops the scoreboard on every FifoRead and checks the line
// waveform, TxBusy, TxDoneTick and pop legality cycle by cycle.
`timescale 1ns/1ps
module tb_uart_fifo_tx;

   localparam int DB  = 8;
   localparam int CPB = 4;
   localparam int NL  = 2;

   logic       clk;
   logic       rst_n;
   logic [1:0] fifo_empty;
   logic [1:0] fifo_rd;
   logic [1:0] tx;
   logic [1:0] busy;
   logic [1:0] done;
   logic [7:0] fifo_data [NL];

   logic [7:0] fifo_q [NL][$];
   logic [7:0] sb_q   [NL][$];
   int         mon_k    [NL];
   logic [7:0] mon_word [NL];
   logic       last_rstn;
   bit         stall;

   int checks   = 0;
   int failures = 0;

   uart_fifo_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
      .Clock        (clk),
      .ResetN       (rst_n),
      .FifoEmpty    (fifo_empty[0]),
      .FifoReadData (fifo_data[0]),
      .FifoRead     (fifo_rd[0]),
      .Tx           (tx[0]),
      .TxBusy       (busy[0]),
      .TxDoneTick   (done[0])
   );

   uart_fifo_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
      .Clock        (clk),
      .ResetN       (rst_n),
      .FifoEmpty    (fifo_empty[1]),
      .FifoReadData (fifo_data[1]),
      .FifoRead     (fifo_rd[1]),
      .Tx           (tx[1]),
      .TxBusy       (busy[1]),
      .TxDoneTick   (done[1])
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int stop_bits(input int l);
      return (l == 0) ? 1 : 2;
   endfunction

   function automatic int frame_len(input int l);
      return (1 + DB + stop_bits(l)) * CPB;
   endfunction

   // Line level k cycles after the pop (k = 1..frame_len): bit slot b is
   // start (0), data LSB first, then stop (1).
   function automatic logic expected_line(input logic [7:0] w, input int k);
      int b;
      b = (k - 1) / CPB;
      if (b == 0) return 1'b0;
      if (b <= DB) return w[b-1];
      return 1'b1;
   endfunction

   task automatic check(input string name, input int l, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s lane%0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int l = 0; l < NL; l++) begin
         fifo_empty[l] = stall || (fifo_q[l].size() == 0);
         fifo_data[l]  = (fifo_q[l].size() > 0) ? fifo_q[l][0] : 8'hFF;
      end
   endtask

   task automatic push(input logic [7:0] w);
      for (int l = 0; l < NL; l++) begin
         fifo_q[l].push_back(w);
         sb_q[l].push_back(w);
      end
      drive();
   endtask

   // One clock: sample pops at negedge, update FIFO models just after posedge.
   task automatic step();
      logic [1:0] popped;
      @(negedge clk);
      popped = fifo_rd;
      @(posedge clk);
      #1;
      for (int l = 0; l < NL; l++) begin
         if (popped[l] && fifo_q[l].size() > 0) void'(fifo_q[l].pop_front());
      end
      drive();
   endtask

   function automatic bit all_idle();
      for (int l = 0; l < NL; l++) begin
         if (fifo_q[l].size() != 0 || mon_k[l] != -1) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (!all_idle() && n < budget) begin
         step();
         n++;
      end
      check(name, 0, all_idle(), 1);
   endtask

   // Per-cycle reference check for one lane.
   task automatic mon_step(input int l);
      logic exp_tx, exp_busy, exp_done, exp_rd;
      bit   in_frame;
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      in_frame = 1'b0;
      if (!last_rstn) begin
         mon_k[l] = -1;
      end else if (mon_k[l] >= 0) begin
         mon_k[l]++;
         in_frame = 1'b1;
         exp_tx   = expected_line(mon_word[l], mon_k[l]);
         exp_busy = 1'b1;
         exp_done = (mon_k[l] == frame_len(l));
         if (mon_k[l] == frame_len(l)) mon_k[l] = -1;
      end
      exp_rd = rst_n && !in_frame && !fifo_empty[l];
      check("tx", l, tx[l], exp_tx);
      check("tx_busy", l, busy[l], exp_busy);
      check("tx_done_tick", l, done[l], exp_done);
      check("fifo_read", l, fifo_rd[l], exp_rd);
      if (exp_rd && fifo_rd[l]) begin
         check("sb_has_word", l, sb_q[l].size() > 0, 1);
         if (sb_q[l].size() > 0) begin
            mon_word[l] = sb_q[l].pop_front();
            mon_k[l]    = 0;
         end
      end
   endtask

   // Monitor: checks both lanes at every falling edge.
   initial begin
      last_rstn = 1'b0;
      for (int l = 0; l < NL; l++) mon_k[l] = -1;
      forever begin
         @(negedge clk);
         for (int l = 0; l < NL; l++) mon_step(l);
         last_rstn = rst_n;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus sequence.
   initial begin
      int n;
      rst_n = 1'b0;
      stall = 1'b0;
      drive();
      repeat (3) step();
      rst_n = 1'b1;

      // Idle with an empty FIFO.
      repeat (20) step();

      // Single frame.
      push(8'hA5);
      wait_idle("drain_a5", 200);

      // Back-to-back frames.
      push(8'h01);
      push(8'h80);
      wait_idle("drain_01_80", 300);

      // Head changes right after the pop (empty FIFO shows 0xFF).
      push(8'h3C);
      wait_idle("drain_3c", 200);

      // Reset during data bit 3, next word popped right after release.
      push(8'hC3);
      push(8'h96);
      n = 0;
      while (mon_k[0] != 18 && n < 200) begin
         step();
         n++;
      end
      check("reach_bit3", 0, mon_k[0] == 18, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wait_idle("drain_after_reset", 300);

      // Alternating pattern, visible on both stop-bit configurations.
      push(8'h55);
      wait_idle("drain_55", 200);

      // Random words with random FIFO stalls.
      for (int i = 0; i < 24; i++) push(8'($urandom));
      n = 0;
      while (!all_idle() && n < 4000) begin
         stall = ($urandom_range(0, 3) == 0);
         drive();
         step();
         n++;
      end
      stall = 1'b0;
      drive();
      check("drain_random", 0, all_idle(), 1);
      repeat (5) step();

      for (int l = 0; l < NL; l++) check("sb_empty_at_end", l, sb_q[l].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
